// File: rtl/code_lock_param.sv
// code_lock_param: parametrised digit-sequence lock with a run-time programmable code.
// After MAX_FAILS consecutive failed attempts, digit entry is locked out for
// LOCKOUT_CYCLES cycles. The lock can also relock automatically after
// AUTO_RELOCK cycles in OPEN.
//   clk, reset_n              : clock (rising edge), async active-low reset
//   digit_valid, digit        : entered digit strobe and value
//   relock                    : relock request (OPEN only)
//   prog_valid, prog_digit    : new-code digit strobe and value (OPEN only), digit 0 first
//   locked, lockout           : registered status
//   fail_pulse, prog_done     : one-cycle event pulses
//   digit_idx                 : digits matched so far in the current attempt
module code_lock_param #(
   parameter int unsigned DIGIT_W        = 4,
   parameter int unsigned CODE_LEN       = 6,
   parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = {4'h6, 4'h5, 4'h2, 4'h5, 4'h3, 4'h3},
   parameter int unsigned MAX_FAILS      = 3,
   parameter int unsigned LOCKOUT_CYCLES = 16,
   parameter int unsigned AUTO_RELOCK    = 0,
   localparam int unsigned IDX_W         = $clog2(CODE_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               digit_valid,
   input  logic [DIGIT_W-1:0] digit,
   input  logic               relock,
   input  logic               prog_valid,
   input  logic [DIGIT_W-1:0] prog_digit,
   output logic               locked,
   output logic               lockout,
   output logic               fail_pulse,
   output logic               prog_done,
   output logic [IDX_W-1:0]   digit_idx
);

   localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
   localparam int unsigned LT_W   = $clog2(LOCKOUT_CYCLES + 1);
   localparam int unsigned RT_W   = (AUTO_RELOCK > 0) ? $clog2(AUTO_RELOCK + 1) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);

   typedef enum logic [1:0] {
      ENTRY   = 2'd0,
      OPEN    = 2'd1,
      LOCKOUT = 2'd2
   } state_t;

   state_t                           state, state_n;
   logic [IDX_W-1:0]                 idx_n;
   logic [FAIL_W-1:0]                fail_cnt, fail_cnt_n;
   logic [LT_W-1:0]                  lt, lt_n;
   logic [RT_W-1:0]                  rt, rt_n;
   logic [IDX_W-1:0]                 ptr, ptr_n;
   logic [CODE_LEN-1:0][DIGIT_W-1:0] code, code_n;
   logic [CODE_LEN-1:0][DIGIT_W-1:0] shadow, shadow_n;
   logic                             locked_n, lockout_n, fail_pulse_n, prog_done_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ENTRY;
         digit_idx  <= '0;
         fail_cnt   <= '0;
         lt         <= '0;
         rt         <= '0;
         ptr        <= '0;
         code       <= DEFAULT_CODE;
         shadow     <= '0;
         locked     <= 1'b1;
         lockout    <= 1'b0;
         fail_pulse <= 1'b0;
         prog_done  <= 1'b0;
      end else begin
         state      <= state_n;
         digit_idx  <= idx_n;
         fail_cnt   <= fail_cnt_n;
         lt         <= lt_n;
         rt         <= rt_n;
         ptr        <= ptr_n;
         code       <= code_n;
         shadow     <= shadow_n;
         locked     <= locked_n;
         lockout    <= lockout_n;
         fail_pulse <= fail_pulse_n;
         prog_done  <= prog_done_n;
      end
   end

   always_comb begin
      state_n      = state;
      idx_n        = digit_idx;
      fail_cnt_n   = fail_cnt;
      lt_n         = lt;
      rt_n         = rt;
      ptr_n        = ptr;
      code_n       = code;
      shadow_n     = shadow;
      fail_pulse_n = 1'b0;
      prog_done_n  = 1'b0;

      case (state)
         ENTRY: begin
            if (digit_valid) begin
               if (digit == code[digit_idx]) begin
                  if (digit_idx == LAST_IDX) begin
                     state_n    = OPEN;
                     idx_n      = '0;
                     fail_cnt_n = '0;
                     rt_n       = RT_W'(AUTO_RELOCK);
                     ptr_n      = '0;
                  end else begin
                     idx_n = digit_idx + 1'b1;
                  end
               end else begin
                  // A mismatch restarts the attempt; the offending digit is consumed.
                  idx_n        = '0;
                  fail_pulse_n = 1'b1;
                  fail_cnt_n   = fail_cnt + 1'b1;
                  if (32'(fail_cnt) + 32'd1 >= MAX_FAILS) begin
                     state_n = LOCKOUT;
                     lt_n    = LT_W'(LOCKOUT_CYCLES);
                  end
               end
            end
         end

         LOCKOUT: begin
            // Leaving on the edge where the timer hits 0 keeps lockout high
            // for exactly LOCKOUT_CYCLES cycles.
            if (lt <= LT_W'(1)) begin
               state_n    = ENTRY;
               lt_n       = '0;
               fail_cnt_n = '0;
               idx_n      = '0;
            end else begin
               lt_n = lt - 1'b1;
            end
         end

         OPEN: begin
            if (relock) begin
               state_n = ENTRY;
               ptr_n   = '0;
            end else if (AUTO_RELOCK != 0 && rt == RT_W'(1)) begin
               state_n = ENTRY;
               rt_n    = '0;
               ptr_n   = '0;
            end else begin
               if (AUTO_RELOCK != 0) rt_n = rt - 1'b1;
               if (prog_valid) begin
                  shadow_n[ptr] = prog_digit;
                  if (ptr == LAST_IDX) begin
                     // Commit the whole code in one edge, including the final digit.
                     code_n      = shadow_n;
                     prog_done_n = 1'b1;
                     ptr_n       = '0;
                  end else begin
                     ptr_n = ptr + 1'b1;
                  end
               end
            end
         end

         default: begin
            state_n = ENTRY;
            idx_n   = '0;
         end
      endcase

      locked_n  = (state_n != OPEN);
      lockout_n = (state_n == LOCKOUT);
   end

endmodule

// File: tb/tb_code_lock_param.sv
// Testbench for code_lock_param: two instances (auto-relock off and 32) share
// stimulus; a reference model predicts outputs into per-DUT queues that a
// negedge monitor pops and compares.
module tb_code_lock_param;

   logic       clk;
   logic       reset_n;
   logic       dv, rl, pv;
   logic [3:0] dg, pdg;

   logic       lk0, lo0, fp0, pd0;
   logic [2:0] ix0;
   logic       lk1, lo1, fp1, pd1;
   logic [2:0] ix1;

   code_lock_param dut0 (
      .clk(clk), .reset_n(reset_n), .digit_valid(dv), .digit(dg),
      .relock(rl), .prog_valid(pv), .prog_digit(pdg),
      .locked(lk0), .lockout(lo0), .fail_pulse(fp0), .prog_done(pd0), .digit_idx(ix0)
   );

   code_lock_param #(.AUTO_RELOCK(32)) dut1 (
      .clk(clk), .reset_n(reset_n), .digit_valid(dv), .digit(dg),
      .relock(rl), .prog_valid(pv), .prog_digit(pdg),
      .locked(lk1), .lockout(lo1), .fail_pulse(fp1), .prog_done(pd1), .digit_idx(ix1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [6:0] q0[$];
   logic [6:0] q1[$];

   // Reference model: plain counters per DUT (index 0 = no auto-relock, 1 = 32).
   int  def_code[6] = '{3, 3, 5, 2, 5, 6};
   bit  m_open[2];
   int  m_lock[2];   // remaining lockout cycles, 0 = none
   int  m_match[2];
   int  m_fails[2];
   int  m_age[2];    // cycles spent open
   int  m_pn[2];     // pending programmed digits
   int  m_code[2][6];
   int  m_pend[2][6];
   bit  m_fp[2];
   bit  m_pd[2];

   function automatic logic [6:0] m_exp(input int u);
      return {!m_open[u], (m_lock[u] > 0), m_fp[u], m_pd[u], 3'(m_match[u])};
   endfunction

   task automatic m_reset();
      for (int u = 0; u < 2; u++) begin
         m_open[u] = 0; m_lock[u] = 0; m_match[u] = 0; m_fails[u] = 0;
         m_age[u] = 0; m_pn[u] = 0; m_fp[u] = 0; m_pd[u] = 0;
         for (int i = 0; i < 6; i++) m_code[u][i] = def_code[i];
      end
   endtask

   task automatic m_step(input int u, input bit v, input int d, input bit r,
                         input bit p, input int pd_in);
      int ar;
      ar = (u == 1) ? 32 : 0;
      m_fp[u] = 0;
      m_pd[u] = 0;
      if (m_lock[u] > 0) begin
         m_lock[u]--;
         if (m_lock[u] == 0) begin
            m_fails[u] = 0;
            m_match[u] = 0;
         end
      end else if (m_open[u]) begin
         m_age[u]++;
         if (r || (ar > 0 && m_age[u] == ar)) begin
            m_open[u] = 0;
            m_pn[u]   = 0;
         end else if (p) begin
            m_pend[u][m_pn[u]] = pd_in;
            m_pn[u]++;
            if (m_pn[u] == 6) begin
               for (int i = 0; i < 6; i++) m_code[u][i] = m_pend[u][i];
               m_pn[u] = 0;
               m_pd[u] = 1;
            end
         end
      end else if (v) begin
         if (d == m_code[u][m_match[u]]) begin
            m_match[u]++;
            if (m_match[u] == 6) begin
               m_open[u]  = 1;
               m_match[u] = 0;
               m_fails[u] = 0;
               m_age[u]   = 0;
            end
         end else begin
            m_match[u] = 0;
            m_fp[u]    = 1;
            m_fails[u]++;
            if (m_fails[u] == 3) m_lock[u] = 16;
         end
      end
   endtask

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got {locked,lockout,fail_pulse,prog_done,idx}=%b, expected %b",
                  name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q0.size() > 0) chk("dut_default", {lk0, lo0, fp0, pd0, ix0}, q0.pop_front());
      if (q1.size() > 0) chk("dut_autorelock32", {lk1, lo1, fp1, pd1, ix1}, q1.pop_front());
   end

   // One clock cycle of stimulus; called just after a rising edge.
   task automatic cyc(input bit v, input int d, input bit r, input bit p, input int pd_in);
      logic [6:0] e0, e1;
      dv = v; dg = 4'(d); rl = r; pv = p; pdg = 4'(pd_in);
      m_step(0, v, d, r, p, pd_in);
      m_step(1, v, d, r, p, pd_in);
      e0 = m_exp(0);
      e1 = m_exp(1);
      @(posedge clk);
      q0.push_back(e0);
      q1.push_back(e1);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
   endtask

   // Digits packed 4 bits each, digit 0 in the LSBs.
   task automatic keys(input int n, input logic [23:0] c);
      for (int i = 0; i < n; i++) cyc(1, int'(c[i*4 +: 4]), 0, 0, 0);
   endtask

   task automatic prog(input int n, input logic [23:0] c);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, int'(c[i*4 +: 4]));
   endtask

   task automatic do_relock();
      cyc(0, 0, 1, 0, 0);
   endtask

   // Reset asserted away from any edge and checked while still held.
   task automatic rst();
      #5;
      dv = 0; rl = 0; pv = 0; dg = '0; pdg = '0;
      reset_n = 1'b0;
      m_reset();
      q0.push_back(m_exp(0));
      q1.push_back(m_exp(1));
      @(negedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      int v, d, r, p, pd_in;
      reset_n = 1'b0;
      dv = 0; rl = 0; pv = 0; dg = '0; pdg = '0;
      rst();
      idle(2);

      // Default code with a gap after the third digit.
      keys(3, 24'h000533);
      idle(2);
      keys(3, 24'h000652);
      idle(2);
      do_relock();

      // Failed attempt; failing digit is not reused as digit 0.
      keys(4, 24'h009533);
      keys(6, 24'h652533);
      do_relock();

      // Three failures -> lockout; code ignored during lockout.
      keys(1, 24'h000001);
      keys(2, 24'h000013);
      keys(1, 24'h000007);
      keys(6, 24'h652533);
      idle(12);
      keys(6, 24'h652533);

      // Reprogram to 1..6 while open.
      idle(1);
      prog(6, 24'h654321);
      do_relock();
      keys(6, 24'h652533);
      keys(6, 24'h654321);

      // Partial program aborted by relock in the same cycle as prog_valid.
      prog(3, 24'h000999);
      cyc(0, 0, 1, 1, 9);
      keys(6, 24'h654321);

      // Auto-relock on the second instance.
      idle(40);

      // Reset mid-entry restores the default code.
      do_relock();
      keys(4, 24'h004321);
      rst();
      keys(6, 24'h652533);
      do_relock();

      // Randomized traffic biased towards the currently expected digit.
      for (int i = 0; i < 600; i++) begin
         v = int'($urandom_range(0, 1));
         d = ($urandom_range(0, 3) != 0) ? m_code[0][m_match[0]] : int'($urandom_range(0, 15));
         r = ($urandom_range(0, 31) == 0) ? 1 : 0;
         p = ($urandom_range(0, 3) == 0) ? 1 : 0;
         pd_in = m_code[0][$urandom_range(0, 5)];
         if ($urandom_range(0, 299) == 0) rst();
         else cyc(v[0], d, r[0], p[0], pd_in);
      end

      idle(2);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/code_lock_param.md
Name: code_lock_param

Overview:
- Parametrised digit-sequence lock: the successor to the fixed 6-digit lock FSM.
- Code length, digit width and default code are parameters; the code can be reprogrammed at run time while open.
- Adds: digit-valid strobe, failed-attempt counter with timed lockout, explicit/automatic relock, progress and status outputs.
- Sits between the keypad decoder and the actuator/status logic.

Parameters:
- DIGIT_W, 4: bits per digit.
- CODE_LEN, 6: digits per code, >=1.
- DEFAULT_CODE, {4'h6,4'h5,4'h2,4'h5,4'h3,4'h3}: CODE_LEN*DIGIT_W bits; digit 0 (first entered) in the LSBs.
- MAX_FAILS, 3: consecutive failed attempts that trigger lockout, >=1.
- LOCKOUT_CYCLES, 16: lockout duration in clk cycles, >=1.
- AUTO_RELOCK, 0: cycles in OPEN before automatic relock; 0 disables.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- digit_valid  in  1  digit strobe; one digit accepted per cycle when high.
- digit  in  DIGIT_W  entered digit.
- relock  in  1  relock request; only acted on in OPEN.
- prog_valid  in  1  new-code digit strobe; only acted on in OPEN.
- prog_digit  in  DIGIT_W  new-code digit, digit 0 first.
- locked  out  1  1 = locked (registered).
- lockout  out  1  1 = lockout active; digits ignored.
- fail_pulse  out  1  one-cycle pulse per failed attempt.
- prog_done  out  1  one-cycle pulse when a new code commits.
- digit_idx  out  clog2(CODE_LEN+1)  digits correctly matched so far.

Behaviour:
- Reset (async assert, sync release):
  - state=ENTRY; idx=0; fail_cnt=0; timers=0; program pointer=0.
  - code=DEFAULT_CODE; locked=1; lockout=0; fail_pulse=0; prog_done=0.
  - Reset mid-operation discards any programmed code and restores DEFAULT_CODE.
- All outputs are registered; every effect is visible the cycle after the accepting edge.
- ENTRY state:
  - digit_valid=0: nothing changes (gaps are allowed).
  - digit_valid=1 and digit==code[idx], idx<CODE_LEN-1: idx+1.
  - digit_valid=1 and digit==code[CODE_LEN-1] with idx=CODE_LEN-1: -> OPEN; locked=0; idx=0; fail_cnt=0.
  - digit_valid=1 and mismatch: idx=0; fail_pulse=1; fail_cnt+1. The failing digit is NOT re-evaluated as digit 0.
  - A mismatch that brings fail_cnt to MAX_FAILS: -> LOCKOUT; lockout=1; timer loaded with LOCKOUT_CYCLES.
- LOCKOUT state:
  - digit_valid, relock and prog_valid are ignored; locked=1.
  - Timer decrements each cycle; lockout is high for exactly LOCKOUT_CYCLES cycles.
  - Timer reaching 0: -> ENTRY; lockout=0; fail_cnt=0; idx=0.
- OPEN state:
  - locked=0; digit_valid is ignored.
  - relock=1: -> ENTRY; locked=1. relock has priority over a same-cycle prog_valid, and the partial program is discarded.
  - AUTO_RELOCK>0: locked returns to 1 exactly AUTO_RELOCK cycles after it fell. Auto-relock aborts a partial program.
  - Programming: each prog_valid writes prog_digit to shadow[ptr], ptr+1.
  - When the CODE_LEN-th digit is written: code<=shadow atomically; prog_done=1; ptr=0; the lock stays OPEN.
  - Leaving OPEN with 0<ptr<CODE_LEN: shadow and ptr are discarded; code is unchanged.
- Widths:
  - fail_cnt is clog2(MAX_FAILS+1) bits; saturation is not needed because lockout clears it.
  - Lockout timer is clog2(LOCKOUT_CYCLES+1) bits; relock timer is clog2(AUTO_RELOCK+1) bits.
- Outside ENTRY, digit_idx reads 0.

Test Plan:
- Defaults (AUTO_RELOCK=0). Reset, then send 3,3,5,2,5,6 with a 2-cycle gap after the 3rd digit -> digit_idx steps 1..5; locked=0 the cycle after the 6th strobe; fail_pulse never asserts.
- Send 3,3,5,9 -> fail_pulse for 1 cycle; digit_idx=0. Then send 3,3,5,2,5,6 -> opens, confirming the failing digit was not reused.
- Three wrong attempts (1 / 3,1 / 7) -> 3 fail_pulses; lockout=1 for exactly 16 cycles. The correct code entered during lockout is ignored (locked stays 1). After lockout, the correct code opens.
- While open: prog_valid with 1,2,3,4,5,6 -> prog_done pulse after the 6th digit. Then relock; 3,3,5,2,5,6 fails; 1,2,3,4,5,6 opens.
- While open: program 3 digits, then relock and prog_valid in the same cycle -> locked=1, no prog_done, old code still opens.
- AUTO_RELOCK=32: open -> locked=1 exactly 32 cycles later. Separately, drop reset_n mid-entry after 4 correct digits -> locked=1, digit_idx=0 immediately; DEFAULT_CODE is restored even after reprogramming.
